vending_major: RTL and testbench

- Single-clock vending-machine controller with an APB-style configuration port.
- Holds a per-item table of price and stock, written and read over the config port.
- Accepts an item selection and sums inserted notes until the price is met, then dispenses: one-cycle o_valid plus item code and change.
- Sits between the register bus and the coin/note acceptor and dispenser front ends.

---
 rtl/vending_pkg.sv | 29 ++
 rtl/vending_item_table.sv | 64 ++++++
 rtl/vending_major.sv | 142 ++++++++++++++
 tb/tb_vending_major.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared widths, pwdata field layout, FSM state type and an index range helper
// for the vending controller.
package vending_pkg;

  localparam int PRICE_W  = 16;
  localparam int COUNT_W  = 7;
  localparam int NOTE_W   = 7;
  localparam int ACC_W    = 17;
  localparam int CHANGE_W = 16;

  // pwdata layout: [15:0] price, [22:16] stock count, [31:23] reserved
  localparam int PW_PRICE_LSB = 0;
  localparam int PW_PRICE_MSB = 15;
  localparam int PW_COUNT_LSB = 16;
  localparam int PW_COUNT_MSB = 22;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2
  } state_e;

  // Index compare done at 32 bits so the result stays meaningful when the
  // table fills the whole index space.
  function automatic logic idx_lt(input logic [31:0] idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/vending_item_table.sv
// Per-item price/stock register file: one config write port, one stock
// decrement port (config write wins on collision), two combinational reads.
module vending_item_table
  import vending_pkg::*;
#(
  parameter int ITEMS    = 64,
  parameter int ITEMSIZE = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [ITEMSIZE-1:0] wr_idx,
  input  logic [PRICE_W-1:0]  wr_price,
  input  logic [COUNT_W-1:0]  wr_count,
  input  logic                dec_en,
  input  logic [ITEMSIZE-1:0] dec_idx,
  input  logic [ITEMSIZE-1:0] cfg_idx,
  output logic [PRICE_W-1:0]  cfg_price,
  output logic [COUNT_W-1:0]  cfg_count,
  input  logic [ITEMSIZE-1:0] buy_idx,
  output logic [PRICE_W-1:0]  buy_price,
  output logic [COUNT_W-1:0]  buy_count
);

  logic [PRICE_W-1:0] price_q [ITEMS];
  logic [COUNT_W-1:0] count_q [ITEMS];

  // Entry update: config write has priority over the dispense decrement.
  // The decrement saturates at zero in case stock was rewritten to 0 mid-purchase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ITEMS; i++) begin
        price_q[i] <= '0;
        count_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < ITEMS; i++) begin
        if (wr_en && (32'(wr_idx) == 32'(i))) begin
          price_q[i] <= wr_price;
          count_q[i] <= wr_count;
        end else if (dec_en && (32'(dec_idx) == 32'(i)) && (count_q[i] != '0)) begin
          count_q[i] <= count_q[i] - COUNT_W'(1);
        end
      end
    end
  end

  // Read ports; indices past the table read as an empty, unpriced entry.
  always_comb begin
    cfg_price = '0;
    cfg_count = '0;
    buy_price = '0;
    buy_count = '0;
    if (idx_lt(32'(cfg_idx), ITEMS)) begin
      cfg_price = price_q[cfg_idx];
      cfg_count = count_q[cfg_idx];
    end
    if (idx_lt(32'(buy_idx), ITEMS)) begin
      buy_price = price_q[buy_idx];
      buy_count = count_q[buy_idx];
    end
  end

endmodule

// File: rtl/vending_major.sv
// Vending controller top: config port into the item table, purchase FSM
// accumulating notes, and registered dispense outputs.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a selection of an in-stock, priced item
// COLLECT  | summing notes for the latched item until its price is met
// DISPENSE | one cycle: load dispense outputs, decrement the item's stock
module vending_major
  import vending_pkg::*;
#(
  parameter int ITEMS    = 64,
  parameter int ITEMSIZE = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         paddr,
  input  logic                pwrite,
  input  logic                psel,
  input  logic [31:0]         pwdata,
  output logic [31:0]         prdata,
  input  logic                i_valid,
  input  logic [NOTE_W-1:0]   note_val,
  input  logic                item_valid,
  input  logic [ITEMSIZE-1:0] item_code,
  output logic                o_valid,
  output logic [ITEMSIZE-1:0] output_item,
  output logic [CHANGE_W-1:0] note_change
);

  state_e                state_q, state_d;
  logic [ITEMSIZE-1:0]   item_q, item_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [CHANGE_W-1:0]   change_q, change_d;
  logic [ACC_W-1:0]      sum;
  logic                  dec_en;
  logic                  sel_ok;

  logic [ITEMSIZE-1:0]   cfg_idx;
  logic                  cfg_idx_ok;
  logic                  wr_en;
  logic [ITEMSIZE-1:0]   buy_idx;
  logic [PRICE_W-1:0]    cfg_price, buy_price;
  logic [COUNT_W-1:0]    cfg_count, buy_count;

  logic                  unused_bits;
  assign unused_bits = ^{paddr[31:ITEMSIZE], pwdata[31:PW_COUNT_MSB+1]};

  assign cfg_idx    = paddr[ITEMSIZE-1:0];
  assign cfg_idx_ok = idx_lt(32'(cfg_idx), ITEMS);
  assign wr_en      = psel && pwrite && cfg_idx_ok;
  // While idle the price port looks at the candidate selection, afterwards at the latched item.
  assign buy_idx    = (state_q == IDLE) ? item_code : item_q;

  vending_item_table #(
    .ITEMS    (ITEMS),
    .ITEMSIZE (ITEMSIZE)
  ) u_table (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_idx    (cfg_idx),
    .wr_price  (pwdata[PW_PRICE_MSB:PW_PRICE_LSB]),
    .wr_count  (pwdata[PW_COUNT_MSB:PW_COUNT_LSB]),
    .dec_en    (dec_en),
    .dec_idx   (item_q),
    .cfg_idx   (cfg_idx),
    .cfg_price (cfg_price),
    .cfg_count (cfg_count),
    .buy_idx   (buy_idx),
    .buy_price (buy_price),
    .buy_count (buy_count)
  );

  // Registered config readback; holds when no read is issued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prdata <= '0;
    end else if (psel && !pwrite) begin
      prdata <= cfg_idx_ok ? {{(32-COUNT_W-PRICE_W){1'b0}}, cfg_count, cfg_price} : '0;
    end
  end

  // Purchase FSM next-state and datapath.
  always_comb begin
    state_d  = state_q;
    item_d   = item_q;
    acc_d    = acc_q;
    change_d = change_q;
    dec_en   = 1'b0;
    sum      = acc_q + ACC_W'(note_val);
    sel_ok   = idx_lt(32'(item_code), ITEMS) && (buy_count != '0) && (buy_price != '0);
    case (state_q)
      IDLE: begin
        if (item_valid && sel_ok) begin
          item_d  = item_code;
          acc_d   = '0;
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (i_valid) begin
          if (sum >= ACC_W'(buy_price)) begin
            change_d = CHANGE_W'(sum - ACC_W'(buy_price));
            state_d  = DISPENSE;
          end else begin
            acc_d = sum;
          end
        end
      end
      DISPENSE: begin
        dec_en  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state register and registered dispense outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      item_q      <= '0;
      acc_q       <= '0;
      change_q    <= '0;
      o_valid     <= 1'b0;
      output_item <= '0;
      note_change <= '0;
    end else begin
      state_q  <= state_d;
      item_q   <= item_d;
      acc_q    <= acc_d;
      change_q <= change_d;
      o_valid  <= (state_q == DISPENSE);
      if (state_q == DISPENSE) begin
        output_item <= item_q;
        note_change <= change_q;
      end
    end
  end

endmodule

// File: tb/tb_vending_major.sv
// Directed bench for vending_major: vector table plus hand sequences for
// price change mid-purchase, write/decrement collision and reset mid-purchase.
module tb_vending_major;

  logic        clk;
  logic        rst;
  logic [31:0] paddr;
  logic        pwrite;
  logic        psel;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        i_valid;
  logic [6:0]  note_val;
  logic        item_valid;
  logic [5:0]  item_code;
  logic        o_valid;
  logic [5:0]  output_item;
  logic [15:0] note_change;

  int n_cmp = 0;
  int n_bad = 0;

  // 48 entries in a 6-bit index space so out-of-range indices are reachable.
  vending_major #(.ITEMS(48), .ITEMSIZE(6)) dut (
    .clk         (clk),
    .rst         (rst),
    .paddr       (paddr),
    .pwrite      (pwrite),
    .psel        (psel),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .i_valid     (i_valid),
    .note_val    (note_val),
    .item_valid  (item_valid),
    .item_code   (item_code),
    .o_valid     (o_valid),
    .output_item (output_item),
    .note_change (note_change)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        psel;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        item_valid;
    logic [5:0]  item_code;
    logic        i_valid;
    logic [6:0]  note_val;
    logic        exp_ov;
    logic [5:0]  exp_item;
    logic [15:0] exp_change;
    logic [31:0] exp_prdata;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ps, logic pw, logic [31:0] pa, logic [31:0] pd,
                              logic iv, logic [5:0] ic, logic nv, logic [6:0] n,
                              logic eov, logic [5:0] eit, logic [15:0] ech, logic [31:0] eprd);
    vec_t v;
    v.psel = ps; v.pwrite = pw; v.paddr = pa; v.pwdata = pd;
    v.item_valid = iv; v.item_code = ic; v.i_valid = nv; v.note_val = n;
    v.exp_ov = eov; v.exp_item = eit; v.exp_change = ech; v.exp_prdata = eprd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    psel = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    item_valid = 1'b0; item_code = '0; i_valid = 1'b0; note_val = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    idle_in();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d;
    step();
  endtask

  task automatic rd(input logic [31:0] a);
    psel = 1'b1; pwrite = 1'b0; paddr = a;
    step();
  endtask

  task automatic sel(input logic [5:0] c);
    item_valid = 1'b1; item_code = c;
    step();
  endtask

  task automatic note(input logic [6:0] n);
    i_valid = 1'b1; note_val = n;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    idle_in();
    rst = 1'b1;
    #3;
    check("reset o_valid",     32'(o_valid),     32'd0);
    check("reset output_item", 32'(output_item), 32'd0);
    check("reset note_change", 32'(note_change), 32'd0);
    check("reset prdata",      prdata,           32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    //            psel pw paddr  pwdata        iv code nv note  ov item chg prdata
    vecs.push_back(mk(1, 0, 0,  0,            0, 0,  0, 0,    0, 0, 0,  32'h0000_0000)); // 0 read item 0 after reset
    vecs.push_back(mk(1, 1, 0,  32'h0064_0096, 0, 0,  0, 0,    0, 0, 0,  32'h0000_0000)); // 1 item0: count 100 price 150
    vecs.push_back(mk(1, 0, 0,  0,            0, 0,  0, 0,    0, 0, 0,  32'h0064_0096)); // 2
    vecs.push_back(mk(1, 1, 48, 32'h0005_0020, 0, 0,  0, 0,    0, 0, 0,  32'h0064_0096)); // 3 write out of range
    vecs.push_back(mk(1, 0, 48, 0,            0, 0,  0, 0,    0, 0, 0,  32'h0000_0000)); // 4 read out of range
    vecs.push_back(mk(1, 0, 0,  0,            0, 0,  0, 0,    0, 0, 0,  32'h0064_0096)); // 5
    vecs.push_back(mk(1, 1, 1,  32'h0000_0032, 0, 0,  0, 0,    0, 0, 0,  32'h0064_0096)); // 6 item1 sold out
    vecs.push_back(mk(1, 1, 2,  32'h0005_0000, 0, 0,  0, 0,    0, 0, 0,  32'h0064_0096)); // 7 item2 unpriced
    vecs.push_back(mk(0, 0, 0,  0,            1, 1,  0, 0,    0, 0, 0,  32'h0064_0096)); // 8 select sold out
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  1, 100,  0, 0, 0,  32'h0064_0096)); // 9 note in IDLE
    vecs.push_back(mk(0, 0, 0,  0,            1, 2,  0, 0,    0, 0, 0,  32'h0064_0096)); // 10 select unpriced
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  1, 100,  0, 0, 0,  32'h0064_0096)); // 11 note in IDLE
    vecs.push_back(mk(0, 0, 0,  0,            1, 48, 0, 0,    0, 0, 0,  32'h0064_0096)); // 12 select out of range
    vecs.push_back(mk(0, 0, 0,  0,            1, 0,  0, 0,    0, 0, 0,  32'h0064_0096)); // 13 select item0
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  1, 100,  0, 0, 0,  32'h0064_0096)); // 14 acc 100
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  1, 100,  0, 0, 0,  32'h0064_0096)); // 15 sum 200 -> DISPENSE
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0, 0,    1, 0, 50, 32'h0064_0096)); // 16 dispense, change 50
    vecs.push_back(mk(1, 0, 0,  0,            0, 0,  0, 0,    0, 0, 50, 32'h0063_0096)); // 17 count 99
    vecs.push_back(mk(0, 0, 0,  0,            1, 0,  0, 0,    0, 0, 50, 32'h0063_0096)); // 18 select item0
    vecs.push_back(mk(0, 0, 0,  0,            1, 2,  1, 100,  0, 0, 50, 32'h0063_0096)); // 19 acc 100, reselect ignored
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  1, 50,   0, 0, 50, 32'h0063_0096)); // 20 exact 150 -> DISPENSE
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0, 0,    1, 0, 0,  32'h0063_0096)); // 21 dispense, change 0
    vecs.push_back(mk(0, 0, 0,  0,            0, 0,  0, 0,    0, 0, 0,  32'h0063_0096)); // 22 single pulse
    vecs.push_back(mk(1, 0, 0,  0,            0, 0,  0, 0,    0, 0, 0,  32'h0062_0096)); // 23 count 98
    vecs.push_back(mk(1, 0, 1,  0,            0, 0,  0, 0,    0, 0, 0,  32'h0000_0032)); // 24 item1 untouched
    vecs.push_back(mk(1, 0, 2,  0,            0, 0,  0, 0,    0, 0, 0,  32'h0005_0000)); // 25 item2 untouched

    foreach (vecs[k]) begin
      psel = vecs[k].psel; pwrite = vecs[k].pwrite; paddr = vecs[k].paddr; pwdata = vecs[k].pwdata;
      item_valid = vecs[k].item_valid; item_code = vecs[k].item_code;
      i_valid = vecs[k].i_valid; note_val = vecs[k].note_val;
      step();
      check($sformatf("v%0d o_valid", k),     32'(o_valid),     32'(vecs[k].exp_ov));
      check($sformatf("v%0d output_item", k), 32'(output_item), 32'(vecs[k].exp_item));
      check($sformatf("v%0d note_change", k), 32'(note_change), 32'(vecs[k].exp_change));
      check($sformatf("v%0d prdata", k),      prdata,           vecs[k].exp_prdata);
    end

    // Price rewritten mid-purchase applies to the next note.
    wr(0, 32'h000A_0096);
    sel(0);
    note(60);
    check("reprice acc60 o_valid", 32'(o_valid), 32'd0);
    wr(0, 32'h000A_0064);
    note(60);
    check("reprice to DISPENSE o_valid", 32'(o_valid), 32'd0);
    step();
    check("reprice o_valid",     32'(o_valid),     32'd1);
    check("reprice note_change", 32'(note_change), 32'd20);
    rd(0);
    check("reprice o_valid drop", 32'(o_valid), 32'd0);
    check("reprice count",        prdata,       32'h0009_0064);

    // Config write on the dispense edge wins over the decrement.
    wr(0, 32'h000A_0096);
    sel(0);
    note(100);
    note(50);
    wr(0, 32'h0007_0096);
    check("collide o_valid",     32'(o_valid),     32'd1);
    check("collide note_change", 32'(note_change), 32'd0);
    rd(0);
    check("collide count", prdata, 32'h0007_0096);

    // Reset in the middle of a purchase.
    wr(5, 32'h0002_001E);
    sel(5);
    note(50);
    step();
    check("item5 o_valid",     32'(o_valid),     32'd1);
    check("item5 output_item", 32'(output_item), 32'd5);
    check("item5 note_change", 32'(note_change), 32'd20);
    sel(0);
    note(100);
    #2 rst = 1'b1;
    #1;
    check("midrst o_valid",     32'(o_valid),     32'd0);
    check("midrst output_item", 32'(output_item), 32'd0);
    check("midrst note_change", 32'(note_change), 32'd0);
    check("midrst prdata",      prdata,           32'd0);
    #2 rst = 1'b0;
    rd(0);
    check("midrst table cleared", prdata, 32'd0);
    wr(0, 32'h0064_0096);
    sel(0);
    note(100);
    check("fresh acc100 o_valid", 32'(o_valid), 32'd0);
    step();
    check("fresh still waiting o_valid", 32'(o_valid), 32'd0);
    note(50);
    check("fresh to DISPENSE o_valid", 32'(o_valid), 32'd0);
    step();
    check("fresh o_valid",     32'(o_valid),     32'd1);
    check("fresh output_item", 32'(output_item), 32'd0);
    check("fresh note_change", 32'(note_change), 32'd0);
    step();
    check("fresh single pulse", 32'(o_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
